// File: rtl/lv_scan_reg_bist_rsp.sv
// lv_scan_reg_bist_rsp
// Responder side of the LV scan-register BIST handshake. Each level request
// from the BIST controller tests the next scan register: save the original
// value, write/read-back/compare two patterns, restore the original, then
// return a one-cycle ack with a pass/fail flag.
// Optional build macro LV_SCAN_BIST_WALK_EN adds a walking-one pass
// (one write/read/compare per data bit) between the last pattern compare
// and the restore write.
// All outputs are flops loaded from next-state values, so there is no
// combinational path from any input to any output.

module lv_scan_reg_bist_rsp #(
  parameter int                    LV_SCAN_REG_NUM = 8,
  parameter int                    SCAN_REG_W      = 8,
  parameter logic [SCAN_REG_W-1:0] SCAN_REG_MASK   = {SCAN_REG_W{1'b1}},
  parameter logic [SCAN_REG_W-1:0] PAT0            = SCAN_REG_W'(8'h55),
  parameter logic [SCAN_REG_W-1:0] PAT1            = SCAN_REG_W'(8'hAA),
  localparam int SCAN_ADDR_W = (LV_SCAN_REG_NUM > 1) ? $clog2(LV_SCAN_REG_NUM) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_bist_en,
  input  logic                   i_bist_scan_reg_req,
  output logic                   o_scan_reg_bist_ack,
  output logic                   o_scan_reg_bist_err,
  output logic                   o_scan_reg_wr_en,
  output logic                   o_scan_reg_rd_en,
  output logic [SCAN_ADDR_W-1:0] o_scan_reg_addr,
  output logic [SCAN_REG_W-1:0]  o_scan_reg_wdata,
  input  logic [SCAN_REG_W-1:0]  i_scan_reg_rdata,
  output logic                   o_bist_busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_ORG,
    S_CAP_ORG,
    S_WR_P0,
    S_RD_P0,
    S_CMP_P0,
    S_WR_P1,
    S_RD_P1,
    S_CMP_P1,
    S_RESTORE,
    S_ACK,
    S_WAIT_LOW
`ifdef LV_SCAN_BIST_WALK_EN
    , S_WR_WALK,
    S_RD_WALK,
    S_CMP_WALK
`endif
  } state_t;

`ifdef LV_SCAN_BIST_WALK_EN
  localparam int BIT_W = (SCAN_REG_W > 1) ? $clog2(SCAN_REG_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SCAN_REG_W - 1);
`endif
  localparam logic [SCAN_ADDR_W-1:0] IDX_LAST = SCAN_ADDR_W'(LV_SCAN_REG_NUM - 1);

  state_t                 state_q, state_d;
  logic [SCAN_ADDR_W-1:0] index_q, index_d;
  logic [SCAN_REG_W-1:0]  orig_q, orig_d;
  logic                   err_q, err_d;
  logic                   abort_q, abort_d;
`ifdef LV_SCAN_BIST_WALK_EN
  logic [BIT_W-1:0]       bit_q, bit_d;
`endif

  logic                   wr_d, rd_d;
  logic [SCAN_REG_W-1:0]  wdata_d;

  // Masked read-back compare: read-only bits (mask 0) never flag an error.
  function automatic logic mismatch(input logic [SCAN_REG_W-1:0] rd,
                                    input logic [SCAN_REG_W-1:0] pat);
    return |((rd ^ pat) & SCAN_REG_MASK);
  endfunction

  // States in which the register may hold a test pattern; leaving them
  // early must go through the restore write.
  function automatic logic pattern_live(input state_t s);
    logic live;
    case (s)
      S_WR_P0, S_RD_P0, S_CMP_P0, S_WR_P1, S_RD_P1, S_CMP_P1: live = 1'b1;
`ifdef LV_SCAN_BIST_WALK_EN
      S_WR_WALK, S_RD_WALK, S_CMP_WALK:                       live = 1'b1;
`endif
      default:                                                live = 1'b0;
    endcase
    return live;
  endfunction

  // Next-state, sequence data and output decode of the next state.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    orig_d  = orig_q;
    err_d   = err_q;
    abort_d = abort_q;
`ifdef LV_SCAN_BIST_WALK_EN
    bit_d   = bit_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_bist_en && i_bist_scan_reg_req) begin
          state_d = S_RD_ORG;
          err_d   = 1'b0;
          abort_d = 1'b0;
        end
      end
      S_RD_ORG:  state_d = S_CAP_ORG;
      S_CAP_ORG: begin
        orig_d  = i_scan_reg_rdata;
        state_d = S_WR_P0;
      end
      S_WR_P0:   state_d = S_RD_P0;
      S_RD_P0:   state_d = S_CMP_P0;
      S_CMP_P0: begin
        err_d   = err_q | mismatch(i_scan_reg_rdata, PAT0);
        state_d = S_WR_P1;
      end
      S_WR_P1:   state_d = S_RD_P1;
      S_RD_P1:   state_d = S_CMP_P1;
      S_CMP_P1: begin
        err_d   = err_q | mismatch(i_scan_reg_rdata, PAT1);
`ifdef LV_SCAN_BIST_WALK_EN
        bit_d   = '0;
        state_d = S_WR_WALK;
`else
        state_d = S_RESTORE;
`endif
      end
`ifdef LV_SCAN_BIST_WALK_EN
      S_WR_WALK: state_d = S_RD_WALK;
      S_RD_WALK: state_d = S_CMP_WALK;
      S_CMP_WALK: begin
        err_d = err_q | mismatch(i_scan_reg_rdata, SCAN_REG_W'(1) << bit_q);
        if (bit_q == BIT_LAST) begin
          state_d = S_RESTORE;
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          state_d = S_WR_WALK;
        end
      end
`endif
      S_RESTORE: begin
        if (abort_q) begin
          state_d = S_IDLE;
          index_d = '0;
          abort_d = 1'b0;
        end else begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_WAIT_LOW;
        index_d = (index_q == IDX_LAST) ? '0 : index_q + SCAN_ADDR_W'(1);
      end
      S_WAIT_LOW: begin
        if (!i_bist_scan_reg_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Closing the BIST window: restore first if a pattern may be in the
    // register, otherwise drop straight back to IDLE at index 0.
    if (!i_bist_en) begin
      if (pattern_live(state_q)) begin
        state_d = S_RESTORE;
        abort_d = 1'b1;
      end else begin
        state_d = S_IDLE;
        index_d = '0;
        abort_d = 1'b0;
      end
    end

    wr_d    = 1'b0;
    rd_d    = 1'b0;
    wdata_d = '0;
    case (state_d)
      S_WR_P0:   begin wr_d = 1'b1; wdata_d = PAT0;   end
      S_WR_P1:   begin wr_d = 1'b1; wdata_d = PAT1;   end
      S_RESTORE: begin wr_d = 1'b1; wdata_d = orig_d; end
      S_RD_ORG, S_RD_P0, S_RD_P1: rd_d = 1'b1;
`ifdef LV_SCAN_BIST_WALK_EN
      S_WR_WALK: begin wr_d = 1'b1; wdata_d = SCAN_REG_W'(1) << bit_d; end
      S_RD_WALK: rd_d = 1'b1;
`endif
      default: ;
    endcase
  end

  // State, sequence registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q             <= S_IDLE;
      index_q             <= '0;
      orig_q              <= '0;
      err_q               <= 1'b0;
      abort_q             <= 1'b0;
`ifdef LV_SCAN_BIST_WALK_EN
      bit_q               <= '0;
`endif
      o_scan_reg_bist_ack <= 1'b0;
      o_scan_reg_bist_err <= 1'b0;
      o_scan_reg_wr_en    <= 1'b0;
      o_scan_reg_rd_en    <= 1'b0;
      o_scan_reg_addr     <= '0;
      o_scan_reg_wdata    <= '0;
      o_bist_busy         <= 1'b0;
    end else begin
      state_q             <= state_d;
      index_q             <= index_d;
      orig_q              <= orig_d;
      err_q               <= err_d;
      abort_q             <= abort_d;
`ifdef LV_SCAN_BIST_WALK_EN
      bit_q               <= bit_d;
`endif
      o_scan_reg_bist_ack <= (state_d == S_ACK);
      o_scan_reg_bist_err <= (state_d == S_ACK) && err_d;
      o_scan_reg_wr_en    <= wr_d;
      o_scan_reg_rd_en    <= rd_d;
      o_scan_reg_addr     <= index_d;
      o_scan_reg_wdata    <= wdata_d;
      o_bist_busy         <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_lv_scan_reg_bist_rsp.sv
// Testbench for lv_scan_reg_bist_rsp: a behavioural scan register file with
// an optional stuck-at fault on read, one DUT with the full compare mask and
// a second with mask 8'hFB sharing the same read data.

module tb_lv_scan_reg_bist_rsp;

`ifdef LV_SCAN_BIST_WALK_EN
  localparam int LAT = 34;
  localparam int NW  = 11;
`else
  localparam int LAT = 10;
  localparam int NW  = 3;
`endif

  logic       clk = 1'b0;
  logic       rst, en, req;
  logic [7:0] rdata;

  logic       a_ack, a_err, a_wr, a_rd, a_busy;
  logic [2:0] a_addr;
  logic [7:0] a_wdata;
  logic       b_ack, b_err, b_wr, b_rd, b_busy;
  logic [2:0] b_addr;
  logic [7:0] b_wdata;

  lv_scan_reg_bist_rsp dut_a (
    .i_clk(clk), .i_rst(rst), .i_bist_en(en), .i_bist_scan_reg_req(req),
    .o_scan_reg_bist_ack(a_ack), .o_scan_reg_bist_err(a_err),
    .o_scan_reg_wr_en(a_wr), .o_scan_reg_rd_en(a_rd),
    .o_scan_reg_addr(a_addr), .o_scan_reg_wdata(a_wdata),
    .i_scan_reg_rdata(rdata), .o_bist_busy(a_busy)
  );

  lv_scan_reg_bist_rsp #(.SCAN_REG_MASK(8'hFB)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_bist_en(en), .i_bist_scan_reg_req(req),
    .o_scan_reg_bist_ack(b_ack), .o_scan_reg_bist_err(b_err),
    .o_scan_reg_wr_en(b_wr), .o_scan_reg_rd_en(b_rd),
    .o_scan_reg_addr(b_addr), .o_scan_reg_wdata(b_wdata),
    .i_scan_reg_rdata(rdata), .o_bist_busy(b_busy)
  );

  always #5 clk = ~clk;

  // Register file model: reads return data one cycle after rd_en.
  logic [7:0] mem [8];
  logic       pl_we = 1'b0;
  logic [2:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  logic [7:0] sm = 8'h00;
  logic [7:0] sv = 8'h00;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (a_wr) mem[a_addr] <= a_wdata;
    if (a_rd) rdata <= (mem[a_addr] & ~sm) | (sv & sm);
  end

  // Transaction logs and protocol monitors.
  logic [7:0] wlog[$];
  logic [2:0] alog[$];
  logic       elog[$];
  logic       blog[$];
  int both_cnt = 0;
  int wd_cnt   = 0;
  int en_cnt   = 0;

  always @(posedge clk) begin
    if (a_wr) wlog.push_back(a_wdata);
    if (a_ack) begin
      alog.push_back(a_addr);
      elog.push_back(a_err);
      blog.push_back(b_err);
    end
    if (a_wr && a_rd) both_cnt++;
    if (!a_wr && a_wdata != 8'h00) wd_cnt++;
    if (!a_ack && a_err) en_cnt++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_we = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req = 1'b0; en = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  // Request, wait (bounded) for ack, then controller handshake.
  task automatic run_req(output int lat);
    lat = 0;
    req = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (a_ack) begin lat = k; break; end
    end
    step();
    req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int lat;
    for (int i = 0; i < 8; i++) preload(3'(i), 8'h3C);
    en = 1'b1; req = 1'b1; rst = 1'b1;
    step(); step();
    checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got %b want 0", a_ack); end
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL rst_err got %b want 0", a_err); end
    checks++; if (a_wr !== 1'b0) begin failures++; $display("FAIL rst_wr got %b want 0", a_wr); end
    checks++; if (a_rd !== 1'b0) begin failures++; $display("FAIL rst_rd got %b want 0", a_rd); end
    checks++; if (a_addr !== 3'd0) begin failures++; $display("FAIL rst_addr got %0d want 0", a_addr); end
    checks++; if (a_wdata !== 8'h00) begin failures++; $display("FAIL rst_wdata got %h want 00", a_wdata); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", a_busy); end
    rst = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (a_ack) begin lat = k; break; end
    end
    checks++; if (lat != LAT) begin failures++; $display("FAIL rst_latency got %0d want %0d", lat, LAT); end
    step();
    checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL rst_ack_width got %b want 0", a_ack); end
    req = 1'b0;
    step();
  endtask

  task automatic test_clean();
    int w0, a0, lat, extra;
    logic [7:0] exp_w [NW];
    pulse_reset();
    preload(3'd0, 8'h3C);
    exp_w[0] = 8'h55;
    exp_w[1] = 8'hAA;
`ifdef LV_SCAN_BIST_WALK_EN
    for (int b = 0; b < 8; b++) exp_w[2+b] = 8'h01 << b;
`endif
    exp_w[NW-1] = 8'h3C;
    w0 = wlog.size();
    a0 = alog.size();
    req = 1'b1;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (a_ack) begin lat = k; break; end
    end
    checks++; if (lat != LAT) begin failures++; $display("FAIL clean_latency got %0d want %0d", lat, LAT); end
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL clean_err got %b want 0", a_err); end
    checks++; if (a_addr !== 3'd0) begin failures++; $display("FAIL clean_ack_addr got %0d want 0", a_addr); end
    // req held well past ack must not start a second test
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (a_ack || a_rd || a_wr) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL clean_held_req got %0d activity want 0", extra); end
    req = 1'b0;
    step(); step();
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL clean_busy got %b want 0", a_busy); end
    checks++; if (wlog.size() - w0 != NW) begin failures++; $display("FAIL clean_nwrites got %0d want %0d", wlog.size() - w0, NW); end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (wlog[w0+i] !== exp_w[i]) begin failures++; $display("FAIL clean_write%0d got %h want %h", i, wlog[w0+i], exp_w[i]); end
    end
    checks++; if (mem[0] !== 8'h3C) begin failures++; $display("FAIL clean_restored got %h want 3c", mem[0]); end
    checks++; if (a_addr !== 3'd1) begin failures++; $display("FAIL clean_next_index got %0d want 1", a_addr); end
    checks++; if (alog.size() - a0 != 1) begin failures++; $display("FAIL clean_acks got %0d want 1", alog.size() - a0); end
  endtask

  task automatic test_stuck();
    int lat;
    pulse_reset();
    preload(3'd0, 8'h3C);
    sm = 8'h04; sv = 8'h00;
    run_req(lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL stuck_latency got %0d want %0d", lat, LAT); end
    checks++; if (elog[$] !== 1'b1) begin failures++; $display("FAIL stuck_err_maskff got %b want 1", elog[$]); end
    checks++; if (blog[$] !== 1'b0) begin failures++; $display("FAIL stuck_err_maskfb got %b want 0", blog[$]); end
    sm = 8'h00;
  endtask

  task automatic test_full_run();
    int lat, a0;
    pulse_reset();
    for (int i = 0; i < 8; i++) preload(3'(i), 8'h10 + 8'(i));
    a0 = alog.size();
    for (int i = 0; i < 8; i++) begin
      run_req(lat);
      checks++; if (lat != LAT) begin failures++; $display("FAIL full_latency%0d got %0d want %0d", i, lat, LAT); end
    end
    for (int k = 0; k < 5; k++) step();
    checks++; if (alog.size() - a0 != 8) begin failures++; $display("FAIL full_acks got %0d want 8", alog.size() - a0); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (alog[a0+i] !== 3'(i)) begin failures++; $display("FAIL full_ack_addr%0d got %0d want %0d", i, alog[a0+i], i); end
      checks++;
      if (mem[i] !== 8'h10 + 8'(i)) begin failures++; $display("FAIL full_restore%0d got %h want %h", i, mem[i], 8'h10 + 8'(i)); end
    end
    checks++; if (a_addr !== 3'd0) begin failures++; $display("FAIL full_wrap got %0d want 0", a_addr); end
  endtask

  task automatic test_abort();
    int lat, w0, a0;
    pulse_reset();
    preload(3'd0, 8'h3C);
    preload(3'd1, 8'h5A);
    run_req(lat);
    w0 = wlog.size();
    a0 = alog.size();
    req = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    checks++; if (a_rd !== 1'b1) begin failures++; $display("FAIL abort_in_rd_p1 got %b want 1", a_rd); end
    en = 1'b0;
    step();
    checks++; if ({a_wr, a_wdata} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL abort_restore got %b/%h want 1/5a", a_wr, a_wdata); end
    step();
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b want 0", a_busy); end
    req = 1'b0;
    for (int k = 0; k < 12; k++) step();
    checks++; if (wlog.size() - w0 != 3) begin failures++; $display("FAIL abort_nwrites got %0d want 3", wlog.size() - w0); end
    checks++; if (alog.size() != a0) begin failures++; $display("FAIL abort_ack got %0d acks want 0", alog.size() - a0); end
    checks++; if (a_addr !== 3'd0) begin failures++; $display("FAIL abort_index got %0d want 0", a_addr); end
    checks++; if (mem[1] !== 8'h5A) begin failures++; $display("FAIL abort_mem got %h want 5a", mem[1]); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int a0;
    pulse_reset();
    preload(3'd0, 8'h3C);
    a0 = alog.size();
    req = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    rst = 1'b1;
    step();
    checks++; if ({a_busy, a_wr, a_rd, a_addr} !== 6'd0) begin failures++; $display("FAIL midrst_outputs got %b want 0", {a_busy, a_wr, a_rd, a_addr}); end
    rst = 1'b0; req = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (mem[0] !== 8'h55) begin failures++; $display("FAIL midrst_no_restore got %h want 55", mem[0]); end
    checks++; if (alog.size() != a0) begin failures++; $display("FAIL midrst_ack got %0d acks want 0", alog.size() - a0); end
  endtask

`ifdef LV_SCAN_BIST_WALK_EN
  task automatic test_walk_stuck();
    int lat;
    pulse_reset();
    preload(3'd0, 8'h00);
    sm = 8'h80; sv = 8'h80;
    run_req(lat);
    checks++; if (lat != 34) begin failures++; $display("FAIL walk_latency got %0d want 34", lat); end
    checks++; if (elog[$] !== 1'b1) begin failures++; $display("FAIL walk_stuck7 got %b want 1", elog[$]); end
    sm = 8'h00; sv = 8'h00;
  endtask
`endif

  task automatic test_invariants();
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL wr_rd_overlap got %0d want 0", both_cnt); end
    checks++; if (wd_cnt != 0) begin failures++; $display("FAIL wdata_idle got %0d want 0", wd_cnt); end
    checks++; if (en_cnt != 0) begin failures++; $display("FAIL err_without_ack got %0d want 0", en_cnt); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 1'b0;
    test_reset();
    test_clean();
    test_stuck();
    test_full_run();
    test_abort();
    test_reset_mid();
`ifdef LV_SCAN_BIST_WALK_EN
    test_walk_stuck();
`endif
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
